// File: rtl/zap_branch_resolve_if.sv
// Branch-resolve bus: ALU-stage branch inputs and the feedback returned
// to the predictor/fetch side. master drives the instruction fields;
// slave is the resolver.
interface zap_branch_resolve_if;
  logic        val;
  logic        is_branch;
  logic        cond_pass;
  logic        taken;
  logic [31:0] pc_plus_8;
  logic [31:0] target;
  logic        clear_from_alu;
  logic        confirm_from_alu;
  logic [31:0] pc_from_alu;
  logic [31:0] redirect_pc;

  modport master (
    output val, is_branch, cond_pass, taken, pc_plus_8, target,
    input  clear_from_alu, confirm_from_alu, pc_from_alu, redirect_pc
  );

  modport slave (
    input  val, is_branch, cond_pass, taken, pc_plus_8, target,
    output clear_from_alu, confirm_from_alu, pc_from_alu, redirect_pc
  );
endinterface

// File: rtl/zap_branch_resolve.sv
// ALU-stage branch resolver. Compares the carried prediction with the
// evaluated condition and answers the predictor with a one-cycle clear
// (plus fetch redirect) or confirm. After a clear, incoming instructions
// are squashed for SHADOW_CYCLES cycles.
// Optional statistics counters are built when BRANCH_STATS_EN is defined;
// otherwise the stats ports are tied to zero.
module zap_branch_resolve #(
  parameter int SHADOW_CYCLES = 2,
  parameter int STAT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear_from_writeback,
  input  logic              i_data_stall,
  zap_branch_resolve_if.slave bus,
  output logic [STAT_W-1:0] o_branch_cnt,
  output logic [STAT_W-1:0] o_mispredict_cnt
);

  typedef enum logic {IDLE = 1'b0, SHADOW = 1'b1} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        clear_q;
  logic        confirm_q;
  logic [31:0] pc_q;
  logic [31:0] redirect_q;

  // A branch is only resolved when idle; shadow-window inputs are wrong-path.
  logic v;
  logic mispredict;
  logic evaluate;

  assign v          = bus.val & bus.is_branch;
  assign mispredict = v & (bus.cond_pass != bus.taken);
  assign evaluate   = !i_clear_from_writeback && !i_data_stall && (state == IDLE);

  // Resolver FSM: pulses, addresses and shadow countdown, all registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      clear_q    <= 1'b0;
      confirm_q  <= 1'b0;
      pc_q       <= 32'd0;
      redirect_q <= 32'd0;
    end else if (i_clear_from_writeback) begin
      // Flush aborts any shadow window; address regs keep their last value.
      state     <= IDLE;
      cnt       <= 4'd0;
      clear_q   <= 1'b0;
      confirm_q <= 1'b0;
    end else if (!i_data_stall) begin
      case (state)
        IDLE: begin
          if (v) pc_q <= bus.pc_plus_8 - 32'd8;
          if (mispredict) begin
            clear_q    <= 1'b1;
            confirm_q  <= 1'b0;
            redirect_q <= bus.cond_pass ? bus.target : (bus.pc_plus_8 - 32'd4);
            state      <= SHADOW;
            cnt        <= 4'(SHADOW_CYCLES);
          end else begin
            clear_q   <= 1'b0;
            confirm_q <= v;
          end
        end
        SHADOW: begin
          clear_q   <= 1'b0;
          confirm_q <= 1'b0;
          cnt       <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.clear_from_alu   = clear_q;
  assign bus.confirm_from_alu = confirm_q;
  assign bus.pc_from_alu      = pc_q;
  assign bus.redirect_pc      = redirect_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] mispredict_cnt;

  // Saturating counters; only i_reset clears them, a writeback flush does not.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (evaluate) begin
      if (v && branch_cnt != '1)              branch_cnt     <= branch_cnt + 1'b1;
      if (mispredict && mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

  assign o_branch_cnt     = branch_cnt;
  assign o_mispredict_cnt = mispredict_cnt;
`else
  assign o_branch_cnt     = '0;
  assign o_mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_zap_branch_resolve.sv
// Directed bench for zap_branch_resolve. The driver pushes a hand-computed
// expectation for every cycle it drives; an independent monitor pops one
// entry per cycle and compares it against the registered outputs.
module tb_zap_branch_resolve;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_clr = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] bcnt, mcnt;

  zap_branch_resolve_if bus ();

  zap_branch_resolve #(.SHADOW_CYCLES(2), .STAT_W(32)) dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_clear_from_writeback (wb_clr),
    .i_data_stall           (stall),
    .bus                    (bus.slave),
    .o_branch_cnt           (bcnt),
    .o_mispredict_cnt       (mcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        cnf;
    logic [31:0] pc;
    logic [31:0] rd;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs settle at the rising edge; sample 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("clear",    32'(bus.clear_from_alu),   32'(e.clr));
        chk("confirm",  32'(bus.confirm_from_alu), 32'(e.cnf));
        chk("pc",       bus.pc_from_alu,           e.pc);
        chk("redirect", bus.redirect_pc,           e.rd);
`ifdef BRANCH_STATS_EN
        chk("branch_cnt",     bcnt, e.bc);
        chk("mispredict_cnt", mcnt, e.mc);
`else
        chk("branch_cnt",     bcnt, 32'd0);
        chk("mispredict_cnt", mcnt, 32'd0);
`endif
      end
    end
  end

  // One cycle of stimulus plus the outputs expected after the next edge.
  task automatic step(input logic r, w, s, v, b, cp, tk,
                      input logic [31:0] p8, tg,
                      input logic e_clr, e_cnf,
                      input logic [31:0] e_pc, e_rd, e_bc, e_mc);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; wb_clr = w; stall = s;
    bus.val = v; bus.is_branch = b; bus.cond_pass = cp; bus.taken = tk;
    bus.pc_plus_8 = p8; bus.target = tg;
    e.clr = e_clr; e.cnf = e_cnf; e.pc = e_pc; e.rd = e_rd; e.bc = e_bc; e.mc = e_mc;
    q.push_back(e);
  endtask

  initial begin
    bus.val = 1'b0; bus.is_branch = 1'b0; bus.cond_pass = 1'b0; bus.taken = 1'b0;
    bus.pc_plus_8 = 32'd0; bus.target = 32'd0;
    //     rst wb  stl v   b   cp  tk  pc+8          target        clr cnf pc            redirect      bc  mc
    // reset with a mispredicting branch on the inputs
    step(1, 0, 0, 1, 1, 1, 0, 32'h40,       32'h2000,     0, 0, 32'h0,        32'h0,        0, 0);
    step(1, 0, 0, 1, 1, 1, 1, 32'h108,      32'h0,        0, 0, 32'h0,        32'h0,        0, 0);
    // correct taken prediction
    step(0, 0, 0, 1, 1, 1, 1, 32'h108,      32'h0,        0, 1, 32'h100,      32'h0,        1, 0);
    // non-branch: no traffic, pc holds
    step(0, 0, 0, 1, 0, 1, 0, 32'h700,      32'h800,      0, 0, 32'h100,      32'h0,        1, 0);
    // mispredict NT->T, then two squashed branches, third evaluated
    step(0, 0, 0, 1, 1, 1, 0, 32'h40,       32'h2000,     1, 0, 32'h38,       32'h2000,     2, 1);
    step(0, 0, 0, 1, 1, 1, 1, 32'h500,      32'h0,        0, 0, 32'h38,       32'h2000,     2, 1);
    step(0, 0, 0, 1, 1, 0, 1, 32'h600,      32'h0,        0, 0, 32'h38,       32'h2000,     2, 1);
    step(0, 0, 0, 1, 1, 1, 1, 32'h208,      32'h0,        0, 1, 32'h200,      32'h2000,     3, 1);
    // mispredict T->NT: redirect to fall-through
    step(0, 0, 0, 1, 1, 0, 1, 32'h40,       32'h2000,     1, 0, 32'h38,       32'h3C,       4, 2);
    // three stalled cycles: pulse and shadow count frozen
    step(0, 0, 1, 1, 1, 1, 0, 32'h900,      32'h5000,     1, 0, 32'h38,       32'h3C,       4, 2);
    step(0, 0, 1, 1, 1, 1, 0, 32'h900,      32'h5000,     1, 0, 32'h38,       32'h3C,       4, 2);
    step(0, 0, 1, 1, 1, 1, 0, 32'h900,      32'h5000,     1, 0, 32'h38,       32'h3C,       4, 2);
    // stall lifts: two shadow cycles still to run
    step(0, 0, 0, 1, 1, 1, 0, 32'h900,      32'h5000,     0, 0, 32'h38,       32'h3C,       4, 2);
    step(0, 0, 0, 1, 1, 1, 0, 32'h900,      32'h5000,     0, 0, 32'h38,       32'h3C,       4, 2);
    // correct not-taken prediction
    step(0, 0, 0, 1, 1, 0, 0, 32'h1008,     32'h0,        0, 1, 32'h1000,     32'h3C,       5, 2);
    // writeback flush beats a mispredicting branch
    step(0, 1, 0, 1, 1, 1, 0, 32'h60,       32'h4000,     0, 0, 32'h1000,     32'h3C,       5, 2);
    // mispredict, then flush aborts the shadow window
    step(0, 0, 0, 1, 1, 1, 0, 32'h60,       32'h4000,     1, 0, 32'h58,       32'h4000,     6, 3);
    step(0, 1, 0, 1, 1, 1, 1, 32'h70,       32'h0,        0, 0, 32'h58,       32'h4000,     6, 3);
    step(0, 0, 0, 1, 1, 1, 1, 32'h10,       32'h0,        0, 1, 32'h8,        32'h4000,     7, 3);
    // 32-bit wrap of both address computations
    step(0, 0, 0, 1, 1, 0, 1, 32'h4,        32'h0,        1, 0, 32'hFFFFFFFC, 32'h0,        8, 4);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'hFFFFFFFC, 32'h0,        8, 4);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'hFFFFFFFC, 32'h0,        8, 4);
    // odd target passed through unmasked
    step(0, 0, 0, 1, 1, 1, 0, 32'h14,       32'h123,      1, 0, 32'hC,        32'h123,      9, 5);
    // reset mid-shadow, then immediate evaluation
    step(1, 0, 0, 1, 1, 1, 0, 32'h14,       32'h123,      0, 0, 32'h0,        32'h0,        0, 0);
    step(0, 0, 0, 1, 1, 1, 1, 32'h28,       32'h0,        0, 1, 32'h20,       32'h0,        1, 0);
    step(0, 0, 0, 0, 1, 1, 1, 32'h28,       32'h0,        0, 0, 32'h20,       32'h0,        1, 0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
